// File: rtl/reg4_serial_tx.sv
// Serialises a 4-bit word as start, D[0..3] (LSB first), optional parity, stop.
// Define PARITY_EN to insert an even-parity bit between bit 3 and stop.
module reg4_serial_tx #(
  parameter int CYCLES_PER_BIT = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       d_valid,
  input  logic [3:0] D,
  output logic       d_ready,
  output logic       tx,
  output logic       busy,
  output logic       done
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] STOP   = 3'd4;
`ifdef PARITY_EN
  localparam logic [2:0] PARITY = 3'd3;
`endif

  localparam logic [7:0] RELOAD = 8'(CYCLES_PER_BIT - 1);

  logic [2:0] state;
  logic [7:0] cnt;
  logic [1:0] idx;
  logic [3:0] shreg;
  logic       bit_end;

  assign bit_end = (cnt == 8'd0);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= 8'd0;
      idx   <= 2'd0;
      // NOTE: the shift register is cleared too, so nothing from an aborted
      // frame can leak into later behaviour.
      shreg <= 4'd0;
    end else begin
      if (state != IDLE) begin
        cnt <= bit_end ? RELOAD : cnt - 8'd1;
      end
      case (state)
        IDLE: begin
          if (d_valid) begin
            shreg <= D;
            cnt   <= RELOAD;
            idx   <= 2'd0;
            state <= START;
          end
        end
        START: begin
          if (bit_end) state <= DATA;
        end
        DATA: begin
          if (bit_end) begin
            // Leave DATA from index 3 rather than wrapping back to bit 0.
            if (idx == 2'd3) begin
`ifdef PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end else begin
              idx <= idx + 2'd1;
            end
          end
        end
`ifdef PARITY_EN
        PARITY: begin
          if (bit_end) state <= STOP;
        end
`endif
        STOP: begin
          if (bit_end) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // NOTE: tx gets a default before the case so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    tx = 1'b1;
    case (state)
      START:  tx = 1'b0;
      DATA:   tx = shreg[idx];
`ifdef PARITY_EN
      PARITY: tx = ^shreg;
`endif
      default: tx = 1'b1;
    endcase
  end

  assign d_ready = (state == IDLE) && !rst;
  assign busy    = (state != IDLE);
  assign done    = (state == STOP) && bit_end;

endmodule

// File: tb/tb_reg4_serial_tx.sv
// Scoreboard bench for reg4_serial_tx: driver predicts frames from a bit-level
// model into a queue, a monitor pops them when the DUT starts a frame.
module tb_reg4_serial_tx;

  localparam int CPB = 3;
`ifdef PARITY_EN
  localparam int NBITS = 7;
`else
  localparam int NBITS = 6;
`endif
  localparam int FRAME_CYC = NBITS * CPB;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       d_valid = 1'b1;
  logic [3:0] D = 4'hF;
  logic       d_ready, tx, busy, done;

  int vectors = 0;
  int miscompares = 0;

  logic [6:0] exp_q[$];
  logic       exp_ready = 1'b0;
  int         rem = 0;

  logic [6:0] cur;
  int         pos = 0;
  logic       in_frame = 1'b0;

  reg4_serial_tx #(.CYCLES_PER_BIT(CPB)) dut (
    .clk(clk), .rst(rst), .d_valid(d_valid), .D(D),
    .d_ready(d_ready), .tx(tx), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic act, input logic exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Line levels of one frame, one entry per bit slot.
  function automatic logic [6:0] frame_levels(input logic [3:0] w);
    logic [6:0] f;
    f = '1;
    f[0] = 1'b0;
    for (int i = 0; i < 4; i++) f[1+i] = w[i];
`ifdef PARITY_EN
    f[5] = ^w;
`endif
    return f;
  endfunction

  // One clock of stimulus; the model decides acceptance from its own count of
  // remaining frame cycles.
  task automatic step(input logic v, input logic [3:0] d, input logic r);
    @(negedge clk);
    d_valid = v;
    D       = d;
    rst     = r;
    if (r) begin
      rem = 0;
    end else if (rem > 0) begin
      rem--;
    end else if (v) begin
      exp_q.push_back(frame_levels(d));
      rem = FRAME_CYC;
    end
    exp_ready = (rem == 0) && !r;
  endtask

  task automatic idle_until_free();
    while (rem != 0) step(1'b0, 4'($urandom), 1'b0);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      check("d_ready", d_ready, exp_ready);
      if (rst) begin
        in_frame = 1'b0;
        check("tx_reset", tx, 1'b1);
        check("busy_reset", busy, 1'b0);
        check("done_reset", done, 1'b0);
      end else begin
        if (!in_frame && busy && exp_q.size() > 0) begin
          cur = exp_q.pop_front();
          in_frame = 1'b1;
          pos = 0;
        end
        if (in_frame) begin
          check("tx_frame", tx, cur[pos / CPB]);
          check("busy_frame", busy, 1'b1);
          check("done_frame", done, pos == FRAME_CYC - 1);
          pos++;
          if (pos == FRAME_CYC) in_frame = 1'b0;
        end else begin
          check("tx_idle", tx, 1'b1);
          check("busy_idle", busy, 1'b0);
          check("done_idle", done, 1'b0);
        end
      end
    end
  end

  initial begin
    // Reset held with d_valid high: reset must win.
    repeat (3) step(1'b1, 4'hF, 1'b1);

    // Directed words, each followed by a drain to idle.
    step(1'b1, 4'b1010, 1'b0);
    idle_until_free();
    step(1'b1, 4'b0001, 1'b0);
    idle_until_free();
    step(1'b1, 4'b0111, 1'b0);
    idle_until_free();
    step(1'b0, 4'h0, 1'b0);

    for (int it = 0; it < 30; it++) begin
      case ($urandom_range(0, 2))
        0: begin
          // d_valid held high with D changing every cycle: back-to-back frames.
          repeat (2 * FRAME_CYC + 5) step(1'b1, 4'($urandom), 1'b0);
        end
        1: begin
          repeat (20) step($urandom_range(0, 3) == 0, 4'($urandom), 1'b0);
        end
        default: begin
          // Abort a frame with reset in its third cycle, then accept at once.
          idle_until_free();
          step(1'b1, 4'($urandom), 1'b0);
          while (rem != FRAME_CYC - 2) step(1'b1, 4'($urandom), 1'b0);
          step(1'b1, 4'($urandom), 1'b1);
          step(1'b1, 4'($urandom), 1'b0);
        end
      endcase
    end

    repeat (FRAME_CYC + 3) step(1'b0, 4'h0, 1'b0);
    check("queue_drained", exp_q.size() == 0, 1'b1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/reg4_serial_tx.md
REG4_SERIAL_TX -- requirements
Module: reg4_serial_tx

Interface
REQ-001 Parameter CYCLES_PER_BIT, default 1: number of clk cycles each serial bit is held on tx; legal range 1..255.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 d_valid  input  1  producer offers a 4-bit word on D.
REQ-005 D  input  4  parallel word to transmit.
REQ-006 d_ready  output  1  block can accept a word this cycle.
REQ-007 tx  output  1  serial line; idles high.
REQ-008 busy  output  1  frame in progress.
REQ-009 done  output  1  one-cycle pulse marking the final cycle of a frame.

Function
REQ-010 The handshake SHALL complete on a rising clk edge where d_valid=1 and d_ready=1; D SHALL be captured into an internal shift register on that edge.
REQ-011 d_ready SHALL be 1 only in state IDLE with rst=0; d_valid while d_ready=0 SHALL be ignored, with no capture and no effect on the frame.
REQ-012 Changes on D after capture SHALL NOT affect the frame in progress.
REQ-013 States: IDLE -> START on accept; START -> DATA; DATA -> PARITY after bit 3 when PARITY_EN is defined, else DATA -> STOP; PARITY -> STOP; STOP -> IDLE.
REQ-014 Each of START, each data bit, PARITY and STOP SHALL drive tx for exactly CYCLES_PER_BIT cycles, timed by an internal down-counter reloaded on every bit boundary.
REQ-015 tx SHALL equal: 1 in IDLE; 0 in START; data bits LSB first (D[0] first) in DATA; the parity bit in PARITY; 1 in STOP.
REQ-016 A 2-bit index SHALL select the data bit; the transition out of DATA SHALL occur when index=3 and the bit counter expires, with no wrap to bit 0.
REQ-017 tx SHALL go low on the first cycle after the accept edge, giving a latency of 1 cycle.
REQ-018 busy SHALL be 1 in every state except IDLE.
REQ-019 done SHALL be 1 only in the last cycle of STOP, and SHALL be 0 at all other times.
REQ-020 Frame length SHALL be 6*CYCLES_PER_BIT cycles, or 7*CYCLES_PER_BIT with PARITY_EN, measured from the first START cycle to the last STOP cycle inclusive.
REQ-021 Back-to-back operation: at least one IDLE cycle, with d_ready=1, SHALL separate consecutive frames; an accept in that cycle SHALL start START on the following cycle.
REQ-022 All outputs SHALL be registered or decoded only from state; there SHALL be no combinational path from D or d_valid to tx.

Reset
REQ-023 While rst=1 at a clk edge, the next state SHALL be IDLE, with tx=1, busy=0, done=0, the bit counter and index cleared, and the shift register set to 0.
REQ-024 d_ready SHALL be 0 during any cycle in which rst=1, and 1 on the first cycle after rst deasserts.
REQ-025 rst asserted mid-frame SHALL abort the frame with tx=1 from the next cycle; no done pulse SHALL be emitted, and a new accept SHALL be possible on the first cycle after rst deasserts.
REQ-026 rst SHALL take priority over a simultaneous d_valid.

Configuration
REQ-027 The macro PARITY_EN, when defined, SHALL insert an even-parity bit (XOR of D[3:0]) between bit 3 and STOP.
REQ-028 With PARITY_EN undefined, the PARITY state and its logic SHALL be absent, and the frame SHALL be start, 4 data bits and stop.

Verification
REQ-029 CYCLES_PER_BIT=1, PARITY_EN undefined, D=4'b1010 accepted -> tx sequence 0,0,1,0,1,1; done in cycle 6; busy=1 for cycles 1-6.
REQ-030 CYCLES_PER_BIT=1, PARITY_EN defined, D=4'b0111 -> tx sequence 0,1,1,1,0,1,1 (parity=1); D=4'b1010 -> parity bit 0.
REQ-031 CYCLES_PER_BIT=3, D=4'b0001 -> each level held 3 cycles; frame is 18 cycles; done only in cycle 18.
REQ-032 d_valid held high with D changing every cycle during a frame -> frame carries only the first captured word; next accept occurs in the IDLE cycle after done.
REQ-033 rst pulsed in cycle 3 of a frame -> tx=1, busy=0 next cycle; no done pulse; d_ready=1 on the first cycle after rst deasserts.
